// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module : ula_pkg
// Purpose: Shared constants for the ALU command sequencer. It holds the
//          3-bit opcode set, the 2-bit sequencer state encoding and the
//          default data width. The data width must match the `ula` ALU.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package ula_pkg;

  // Default data width. The sequencer and the ALU must agree on it.
  localparam int LARGURA_PADRAO = 4;

  // Opcodes. Codes 000-101 are also the ALU selector values.
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_READ = 3'b111;

  // Sequencer states
  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] EXECUTA  = 2'd1;
  localparam logic [1:0] RESPOSTA = 2'd2;

endpackage : ula_pkg
`default_nettype wire

// File: rtl/ula_sequenciador_banco_registradores.sv
`default_nettype none
// ============================================================================
// Module : banco_registradores
// Purpose: A NUM_REGS x LARGURA register file. It has two asynchronous read
//          ports and one synchronous write port. The asynchronous active-low
//          reset clears every entry to 0.
// Ports  : clk, rst_n                 - clock, async active-low reset
//          rd_idx_a/b, rd_dado_a/b    - combinational read ports
//          wr_en, wr_idx, wr_dado     - write port, applied on rising edge
// Rev    : 1.0 - initial release
// ============================================================================
module banco_registradores #(
  parameter  int LARGURA  = 4,
  parameter  int NUM_REGS = 4,
  localparam int IDX      = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX-1:0]     rd_idx_a,
  input  logic [IDX-1:0]     rd_idx_b,
  output logic [LARGURA-1:0] rd_dado_a,
  output logic [LARGURA-1:0] rd_dado_b,
  input  logic               wr_en,
  input  logic [IDX-1:0]     wr_idx,
  input  logic [LARGURA-1:0] wr_dado
);

  logic [LARGURA-1:0] r_regs [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_regs[i] <= '0;
      end else if (wr_en && (wr_idx == IDX'(i))) begin
        r_regs[i] <= wr_dado;
      end
    end
  end

  assign rd_dado_a = r_regs[rd_idx_a];
  assign rd_dado_b = r_regs[rd_idx_b];

endmodule : banco_registradores
`default_nettype wire

// File: rtl/ula_sequenciador.sv
`default_nettype none
// ============================================================================
// Module : ula_sequenciador
// Purpose: Command-side initiator for the combinational 4-bit ALU (`ula`).
//          It accepts one register-level command over cmd_valid/cmd_ready
//          and reads the operands from the register file. It drives the ALU
//          for one cycle, then writes the result back. The result is
//          returned over res_valid/res_ready. Only one command is in flight
//          at a time.
// Ports  : clk, rst_n                         - clock, async active-low reset
//          cmd_valid/ready, cmd_op, cmd_src_a,
//          cmd_src_b, cmd_dst, cmd_imm,
//          cmd_carry_in                       - command channel
//          ula_a, ula_b, ula_seletor,
//          ula_carry_in                       - registered ALU drive
//          ula_resultado, ula_carry_out       - ALU response
//          res_valid/ready, res_dado          - result channel
//          res_carry                          - current carry flag
// Config : ULA_SEQ_CARRY_CHAIN_EN - when defined, ADD takes its carry-in
//          from the carry flag instead of cmd_carry_in. This allows
//          multi-word addition.
// Rev    : 1.0 - initial release
// ============================================================================
module ula_sequenciador
  import ula_pkg::*;
#(
  parameter  int LARGURA  = LARGURA_PADRAO,
  parameter  int NUM_REGS = 4,
  localparam int IDX      = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [IDX-1:0]     cmd_src_a,
  input  logic [IDX-1:0]     cmd_src_b,
  input  logic [IDX-1:0]     cmd_dst,
  input  logic [LARGURA-1:0] cmd_imm,
  input  logic               cmd_carry_in,
  output logic [LARGURA-1:0] ula_a,
  output logic [LARGURA-1:0] ula_b,
  output logic [2:0]         ula_seletor,
  output logic               ula_carry_in,
  input  logic [LARGURA-1:0] ula_resultado,
  input  logic               ula_carry_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [LARGURA-1:0] res_dado,
  output logic               res_carry
);

  logic [1:0]         r_estado;
  logic [1:0]         w_prox_estado;
  logic [2:0]         r_op;
  logic [IDX-1:0]     r_dst;
  logic [LARGURA-1:0] r_imm;
  logic               r_carry;
  logic               w_aceita;
  logic               w_cin;
  logic [LARGURA-1:0] w_rd_a;
  logic [LARGURA-1:0] w_rd_b;
  logic [LARGURA-1:0] w_res_novo;
  logic               w_wr_en;

  banco_registradores #(
    .LARGURA  (LARGURA),
    .NUM_REGS (NUM_REGS)
  ) u_banco (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_a  (cmd_src_a),
    .rd_idx_b  (cmd_src_b),
    .rd_dado_a (w_rd_a),
    .rd_dado_b (w_rd_b),
    .wr_en     (w_wr_en),
    .wr_idx    (r_dst),
    .wr_dado   (w_res_novo)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      OCIOSO:   if (cmd_valid) w_prox_estado = EXECUTA;
      EXECUTA:  w_prox_estado = RESPOSTA;
      RESPOSTA: if (res_ready) w_prox_estado = OCIOSO;
      default:  w_prox_estado = OCIOSO;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (r_estado)
      OCIOSO:   cmd_ready = 1'b1;
      RESPOSTA: res_valid = 1'b1;
      default: begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath
  assign w_aceita = (r_estado == OCIOSO) && cmd_valid;

`ifdef ULA_SEQ_CARRY_CHAIN_EN
  // Chained ADD: the carry of the previous ADD feeds the next one.
  assign w_cin = (cmd_op == OP_ADD) ? r_carry : cmd_carry_in;
`else
  assign w_cin = cmd_carry_in;
`endif

  // LOAD ignores the ALU. READ returns operand A, which was latched from
  // the register file when the command was accepted.
  always_comb begin
    case (r_op)
      OP_LOAD: w_res_novo = r_imm;
      OP_READ: w_res_novo = ula_a;
      default: w_res_novo = ula_resultado;
    endcase
  end

  assign w_wr_en = (r_estado == EXECUTA) && (r_op != OP_READ);

  // The operands are captured at acceptance. A destination that equals a
  // source therefore cannot disturb the value the ALU is working on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= OP_AND;
      r_dst        <= '0;
      r_imm        <= '0;
      ula_a        <= '0;
      ula_b        <= '0;
      ula_seletor  <= 3'b000;
      ula_carry_in <= 1'b0;
      res_dado     <= '0;
      r_carry      <= 1'b0;
    end else begin
      if (w_aceita) begin
        r_op         <= cmd_op;
        r_dst        <= cmd_dst;
        r_imm        <= cmd_imm;
        ula_a        <= w_rd_a;
        ula_b        <= w_rd_b;
        ula_seletor  <= cmd_op;
        ula_carry_in <= w_cin;
      end
      if (r_estado == EXECUTA) begin
        res_dado <= w_res_novo;
        // Only ADD produces a carry. Every other op keeps the flag.
        if (r_op == OP_ADD) begin
          r_carry <= ula_carry_out;
        end
      end
    end
  end

  assign res_carry = r_carry;

endmodule : ula_sequenciador
`default_nettype wire
